// File: rtl/wait_seq_pkg.sv
// Shared definitions for the wait sequencer and its wait-timer partner.
//   seq_state_t : sequencer FSM states
//   DEF_BITS    : default delay width (period / CLK_Div)
//   DEF_NSTEP   : default step-count width (num_steps / steps_done)
package wait_seq_pkg;

  localparam int unsigned DEF_BITS  = 4;
  localparam int unsigned DEF_NSTEP = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    WAIT   = 3'd2,
    EMIT   = 3'd3,
    FINISH = 3'd4
  } seq_state_t;

endpackage

// File: rtl/wait_counter.sv
// Wait timer partner for wait_sequencer.
// While flag is high it counts sampled cycles and raises completed once
// CLK_Div+1 high cycles have been seen; completed then holds until flag drops.
// With flag low the count and completed are cleared on the next edge.
// Ports:
//   CLOCK_50M  in   system clock
//   reset      in   synchronous active-high reset
//   flag       in   enable from the sequencer
//   CLK_Div    in   delay value (BITS)
//   completed  out  registered done level
module wait_counter
  import wait_seq_pkg::*;
#(
  parameter int unsigned BITS = DEF_BITS
) (
  input  logic            CLOCK_50M,
  input  logic            reset,
  input  logic            flag,
  input  logic [BITS-1:0] CLK_Div,
  output logic            completed
);

  logic [BITS-1:0] count;

  // Count stops at CLK_Div so it can never wrap while completed is held.
  always_ff @(posedge CLOCK_50M) begin
    if (reset || !flag) begin
      count     <= '0;
      completed <= 1'b0;
    end else if (!completed) begin
      if (count == CLK_Div) begin
        completed <= 1'b1;
      end else begin
        count <= count + BITS'(1);
      end
    end
  end

endmodule

// File: rtl/wait_sequencer.sv
// Initiator side of the flag / CLK_Div / completed wait-timer handshake.
// Programs a delay, raises flag, waits for completed, then offers one step
// downstream on a valid/ready handshake. Repeats num_steps times, or runs
// until stop when num_steps is 0.
// Ports:
//   CLOCK_50M   in   system clock
//   reset       in   synchronous active-high reset
//   start       in   run request, sampled only in IDLE
//   stop        in   abort request, honoured in every active state
//   period      in   delay per step, latched on accepted start (BITS)
//   num_steps   in   steps per run, 0 = continuous (NSTEP)
//   flag        out  timer enable, high only in WAIT
//   CLK_Div     out  latched period (BITS)
//   completed   in   timer done level
//   step_valid  out  step strobe, held until step_ready
//   step_ready  in   downstream accept
//   busy        out  high outside IDLE
//   done        out  1-cycle pulse at normal end of a finite run
//   aborted     out  1-cycle pulse when stop ends an active run
//   steps_done  out  accepted steps this run (NSTEP, wraps)
module wait_sequencer
  import wait_seq_pkg::*;
#(
  parameter int unsigned BITS  = DEF_BITS,
  parameter int unsigned NSTEP = DEF_NSTEP
) (
  input  logic             CLOCK_50M,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [BITS-1:0]  period,
  input  logic [NSTEP-1:0] num_steps,
  output logic             flag,
  output logic [BITS-1:0]  CLK_Div,
  input  logic             completed,
  output logic             step_valid,
  input  logic             step_ready,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [NSTEP-1:0] steps_done
);

  seq_state_t       state;
  logic [NSTEP-1:0] num_q;
  logic [NSTEP-1:0] steps_next;

  assign steps_next = steps_done + NSTEP'(1);

  // Single FSM with step counter; every output is a register.
  always_ff @(posedge CLOCK_50M) begin
    if (reset) begin
      state      <= IDLE;
      flag       <= 1'b0;
      step_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      CLK_Div    <= '0;
      steps_done <= '0;
      num_q      <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      // Abort takes priority; a step accepted in this cycle is dropped.
      if (stop && (state != IDLE)) begin
        state      <= IDLE;
        flag       <= 1'b0;
        step_valid <= 1'b0;
        busy       <= 1'b0;
        aborted    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              state      <= ARM;
              busy       <= 1'b1;
              CLK_Div    <= period;
              num_q      <= num_steps;
              steps_done <= '0;
            end
          end
          // Hold flag low until the timer has visibly cleared completed,
          // so a stale level from the previous step is never counted.
          ARM: begin
            if (!completed) begin
              state <= WAIT;
              flag  <= 1'b1;
            end
          end
          WAIT: begin
            if (completed) begin
              state      <= EMIT;
              flag       <= 1'b0;
              step_valid <= 1'b1;
            end
          end
          EMIT: begin
            if (step_ready) begin
              step_valid <= 1'b0;
              steps_done <= steps_next;
              if ((num_q != '0) && (steps_next == num_q)) begin
                state <= FINISH;
                done  <= 1'b1;
              end else begin
                state <= ARM;
              end
            end
          end
          FINISH: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state      <= IDLE;
            flag       <= 1'b0;
            step_valid <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wait_sequencer.sv
// Bench for wait_sequencer paired with wait_counter (BITS=4, NSTEP=8).
module tb_wait_sequencer;

  localparam int unsigned BITS  = 4;
  localparam int unsigned NSTEP = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic             stop;
  logic [BITS-1:0]  period;
  logic [NSTEP-1:0] num_steps;
  logic             flag;
  logic [BITS-1:0]  clk_div;
  logic             completed;
  logic             step_valid;
  logic             step_ready;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [NSTEP-1:0] steps_done;

  int checks   = 0;
  int failures = 0;

  wait_sequencer #(.BITS(BITS), .NSTEP(NSTEP)) dut (
    .CLOCK_50M (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .period    (period),
    .num_steps (num_steps),
    .flag      (flag),
    .CLK_Div   (clk_div),
    .completed (completed),
    .step_valid(step_valid),
    .step_ready(step_ready),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .steps_done(steps_done)
  );

  wait_counter #(.BITS(BITS)) u_timer (
    .CLOCK_50M(clk),
    .reset    (reset),
    .flag     (flag),
    .CLK_Div  (clk_div),
    .completed(completed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase of the run: 0 idle, 1 rearming timer, 2 timing, 3 offering step, 4 finishing.
  int   m_phase  = 0;
  int   m_div    = 0;
  int   m_target = 0;
  int   m_steps  = 0;
  bit   m_done   = 0;
  bit   m_abort  = 0;
  int   m_hi     = 0;
  bit   m_comp   = 0;
  bit   m_ready  = 0;

  always @(posedge clk) begin
    // Timer: completed after div+1 consecutive cycles with flag high.
    if (reset || (m_phase != 2)) begin
      m_hi   = 0;
      m_comp = 0;
    end else begin
      m_hi   = m_hi + 1;
      m_comp = (m_hi >= m_div + 1);
    end
    m_done  = 0;
    m_abort = 0;
    if (reset) begin
      m_phase  = 0;
      m_div    = 0;
      m_target = 0;
      m_steps  = 0;
      m_ready  = 1;
    end else if (stop && m_phase != 0) begin
      m_phase = 0;
      m_abort = 1;
    end else begin
      case (m_phase)
        0: if (start && !stop) begin
             m_phase  = 1;
             m_div    = int'(period);
             m_target = int'(num_steps);
             m_steps  = 0;
           end
        1: if (!completed) m_phase = 2;
        2: if (completed) m_phase = 3;
        3: if (step_ready) begin
             m_steps = (m_steps + 1) % 256;
             if (m_target != 0 && m_steps == m_target) begin
               m_phase = 4;
               m_done  = 1;
             end else begin
               m_phase = 1;
             end
           end
        default: m_phase = 0;
      endcase
    end
  end

  // Every-cycle comparison of the DUT and timer against the model.
  always @(negedge clk) begin
    if (m_ready) begin
      check("cyc_flag",       32'(flag),       32'(m_phase == 2));
      check("cyc_step_valid", 32'(step_valid), 32'(m_phase == 3));
      check("cyc_busy",       32'(busy),       32'(m_phase != 0));
      check("cyc_done",       32'(done),       32'(m_done));
      check("cyc_aborted",    32'(aborted),    32'(m_abort));
      check("cyc_steps_done", 32'(steps_done), 32'(m_steps));
      check("cyc_clk_div",    32'(clk_div),    32'(m_div));
      check("cyc_completed",  32'(completed),  32'(m_comp));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(input logic [BITS-1:0] p, input logic [NSTEP-1:0] n);
    period    = p;
    num_steps = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int  flag_cyc;
    int  valid_cyc;
    bit  seen;

    reset = 1'b1; start = 1'b0; stop = 1'b0;
    period = '0; num_steps = '0; step_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("rst_flag", 32'(flag), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_steps_done", 32'(steps_done), 0);
    check("rst_clk_div", 32'(clk_div), 0);
    tick();
    reset = 1'b0;
    tick();

    // 1: period=3, two steps, ready tied high.
    pulse_start(4'd3, 8'd2);
    flag_cyc = 0; valid_cyc = 0; seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      flag_cyc  += int'(flag);
      valid_cyc += int'(step_valid);
      if (done) seen = 1;
    end
    check("t1_done_pulse", 32'(seen), 1);
    check("t1_flag_cycles", 32'(flag_cyc), 10);
    check("t1_valid_cycles", 32'(valid_cyc), 2);
    check("t1_steps_done", 32'(steps_done), 2);
    @(negedge clk);
    check("t1_busy_low", 32'(busy), 0);
    check("t1_done_one_cycle", 32'(done), 0);

    // 2: period=0, continuous, stop after 5 steps.
    tick();
    pulse_start(4'd0, 8'd0);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (steps_done == 8'd5) seen = 1;
    end
    check("t2_reached_5", 32'(seen), 1);
    stop = 1'b1;
    @(posedge clk); #2;
    stop = 1'b0;
    @(negedge clk);
    check("t2_aborted", 32'(aborted), 1);
    check("t2_flag_low", 32'(flag), 0);
    check("t2_busy_low", 32'(busy), 0);
    check("t2_steps_done", 32'(steps_done), 5);
    @(negedge clk);
    check("t2_aborted_one_cycle", 32'(aborted), 0);

    // 3: downstream stalls for 4 cycles in EMIT.
    tick();
    step_ready = 1'b0;
    pulse_start(4'd2, 8'd1);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (step_valid) seen = 1;
    end
    check("t3_valid_seen", 32'(seen), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_valid_held", 32'(step_valid), 1);
      check("t3_flag_low", 32'(flag), 0);
      check("t3_steps_hold", 32'(steps_done), 0);
    end
    step_ready = 1'b1;
    @(posedge clk); #2;
    step_ready = 1'b0;
    @(negedge clk);
    check("t3_steps_once", 32'(steps_done), 1);
    check("t3_valid_drop", 32'(step_valid), 0);
    check("t3_done", 32'(done), 1);
    tick(); tick();
    step_ready = 1'b1;

    // 4: start and stop together in IDLE.
    period = 4'd3; num_steps = 8'd2;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    check("t4_busy", 32'(busy), 0);
    check("t4_aborted", 32'(aborted), 0);
    @(negedge clk);
    check("t4_still_idle", 32'(busy), 0);

    // 5: reset while timing the second step.
    tick();
    pulse_start(4'd5, 8'd3);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (steps_done == 8'd1 && flag) seen = 1;
    end
    check("t5_in_wait", 32'(seen), 1);
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    check("t5_flag", 32'(flag), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_steps_done", 32'(steps_done), 0);
    check("t5_done", 32'(done), 0);
    check("t5_aborted", 32'(aborted), 0);
    @(negedge clk);
    check("t5_no_pulse_late", 32'(done | aborted), 0);

    // 6: start with a new period during WAIT is ignored.
    tick();
    pulse_start(4'd3, 8'd1);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (flag) seen = 1;
    end
    check("t6_in_wait", 32'(seen), 1);
    period = 4'd9;
    start  = 1'b1;
    @(posedge clk); #2;
    start  = 1'b0;
    @(negedge clk);
    check("t6_clk_div_kept", 32'(clk_div), 3);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("t6_done", 32'(seen), 1);
    check("t6_steps_done", 32'(steps_done), 1);
    check("t6_clk_div_end", 32'(clk_div), 3);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
